usb_serial_in_ep: RTL

- Bulk IN endpoint for the USB-serial function.
- Sits directly upstream of the full-speed protocol engine and drives one slot of its IN endpoint interface (in_ep_req/grant/data_free/data_put/data/data_done/stall/acked).
- Accepts a byte stream from user logic through a valid/ready port and buffers it in a local FIFO.
- Packetises the buffered bytes into max-size packets or flush-timeout short packets, and commits each packet to the engine. Follows a full packet with a ZLP when the FIFO is empty.

---
 rtl/usb_serial_pkg.sv | 22 ++
 rtl/usb_serial_fifo.sv | 61 ++++++
 rtl/usb_serial_in_ep.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/usb_serial_pkg.sv
// Shared types and defaults for the USB-serial bulk IN endpoint.
// Holds the packetiser state encoding and counter sizing helpers.
package usb_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_PUT,
        ST_DONE,
        ST_WAIT_ACK
    } ep_state_t;

    localparam int DEF_FIFO_DEPTH   = 64;
    localparam int DEF_MAX_PKT      = 32;
    localparam int DEF_FLUSH_CYCLES = 48000;

    // Bits needed to hold the value max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/usb_serial_fifo.sv
// First-word-fall-through byte FIFO between user logic and the packetiser.
// Head byte is visible combinationally; push is ignored when full, pop when empty.
module usb_serial_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_serial_in_ep.sv
// Bulk IN endpoint: buffers user bytes and packetises them for the FS engine.
// Full packets go out back to back; partial ones after an idle flush timeout.
module usb_serial_in_ep
    import usb_serial_pkg::*;
#(
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int MAX_PKT      = DEF_MAX_PKT,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] uart_in_data,
    input  logic       uart_in_valid,
    output logic       uart_in_ready,
    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    output logic       in_ep_stall,
    input  logic       in_ep_acked,
    output logic       busy
);

    localparam int PW = cnt_width(MAX_PKT);
    localparam int TW = cnt_width(FLUSH_CYCLES);
    localparam int TLAST_I = (FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0;

    localparam logic [PW-1:0] PKT_MAX    = PW'(MAX_PKT);
    localparam logic [PW-1:0] PKT_LAST   = PW'(MAX_PKT - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TLAST_I);

    ep_state_t       state;
    logic [PW-1:0]   pkt_cnt;
    logic [TW-1:0]   timer;
    logic            zlp_pending;

    logic            fifo_push;
    logic [7:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic            put;
    logic            timer_last;

    assign uart_in_ready = !fifo_full;
    assign fifo_push     = uart_in_valid && !fifo_full;

    // A byte moves into the engine whenever granted, data is queued and room remains.
    assign put = (state == ST_PUT) && in_ep_grant && !fifo_empty
                 && (pkt_cnt < PKT_MAX);

    // The flush fires as the idle count reaches its last value.
    assign timer_last = (timer >= TIMER_LAST);

    assign in_ep_data_put  = put;
    assign in_ep_data      = put ? fifo_head : 8'h00;
    assign in_ep_req       = (state == ST_REQ) || (state == ST_PUT)
                             || (state == ST_DONE);
    assign in_ep_data_done = (state == ST_DONE);
    assign in_ep_stall     = 1'b0;

    usb_serial_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (uart_in_data),
        .pop       (put),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Packetiser: request, stream bytes, commit, then wait for the host ACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pkt_cnt     <= '0;
            timer       <= '0;
            zlp_pending <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!enable) begin
                        zlp_pending <= 1'b0;
                    end else if (!fifo_empty || zlp_pending) begin
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (in_ep_grant && in_ep_data_free) begin
                        state   <= ST_PUT;
                        pkt_cnt <= '0;
                        timer   <= '0;
                    end
                end
                ST_PUT: begin
                    if (put) begin
                        pkt_cnt <= pkt_cnt + 1'b1;
                        timer   <= '0;
                        if (pkt_cnt == PKT_LAST) begin
                            state <= ST_DONE;
                        end
                    end else if (fifo_empty) begin
                        // Empty with nothing sent is only reachable for a ZLP.
                        if (pkt_cnt == '0) begin
                            state <= ST_DONE;
                        end else if (in_ep_grant) begin
                            if (timer_last) begin
                                state <= ST_DONE;
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    zlp_pending <= (pkt_cnt == PKT_MAX) && fifo_empty;
                    state       <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (in_ep_acked) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Activity flag, one cycle behind the state and FIFO occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE) || (fifo_count != '0);
        end
    end

endmodule
